button_conditioner: RTL
=======================

# button_conditioner

Front-end conditioning stage for the stopwatch push-buttons. It synchronises a raw mechanical button input to `clk`, debounces it, and emits clean single-cycle events. `press_pulse` drives the stopwatch start/stop input. `long_press_pulse` drives its counter reset. One instance is used per physical button.

## Interface
- `DEBOUNCE_CYCLES`, default 260000: number of consecutive stable cycles required to accept a level change (10 ms at 26 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 52000000: hold duration after press confirmation that triggers the long-press event (2 s at 26 MHz); must be ≥ 2.
- `ACTIVE_LOW`, default 0: 1 = `button_raw` reads 0 when pressed; the input is inverted before synchronisation.
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `button_raw` input 1: unsynchronised, bouncing button pin.
- `pressed_level` output 1: debounced button state, 1 = pressed.
- `press_pulse` output 1: one-cycle pulse on a confirmed press.
- `release_pulse` output 1: one-cycle pulse on a confirmed release.
- `long_press_pulse` output 1: one-cycle pulse, at most once per press, when the hold reaches `LONG_PRESS_CYCLES`.

## Operation
- **Input path:** polarity normalisation, then a 2-flop synchroniser giving `sync_q`. Both flops reset to 0 (not pressed).
- **FSM states:** RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK. Reset state is RELEASED.
- **Debounce counter:** `db_cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- **RELEASED:**
  - `sync_q`=1 → PRESS_CHECK, `db_cnt`←0.
- **PRESS_CHECK:**
  - `sync_q`=0 → RELEASED; no event.
  - Else if `db_cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED, `press_pulse`←1, `hold_cnt`←0.
  - Else `db_cnt`++.
- **PRESSED:**
  - `sync_q`=0 → RELEASE_CHECK, `db_cnt`←0.
- **RELEASE_CHECK:**
  - `sync_q`=1 → PRESSED; no event.
  - Else if `db_cnt`==`DEBOUNCE_CYCLES`-1 → RELEASED, `release_pulse`←1.
  - Else `db_cnt`++.
- **Hold counter:** `hold_cnt`, width `$clog2(LONG_PRESS_CYCLES)`.
  - Increments in PRESSED and RELEASE_CHECK, so bounce during release does not lose hold time.
  - Saturates at `LONG_PRESS_CYCLES`-1; never wraps.
- **Long-press flag:** `long_done`.
  - When `hold_cnt`==`LONG_PRESS_CYCLES`-1 and `long_done`=0: `long_press_pulse`←1, `long_done`←1.
  - `long_done` and `hold_cnt` clear on entry to RELEASED.
- **Level output:** `pressed_level` = 1 in PRESSED or RELEASE_CHECK, else 0. It is registered (decoded from the state register, no input-to-output path).
- **Exclusivity:** `press_pulse`, `release_pulse` and `long_press_pulse` are registered and mutually exclusive in any cycle. Each is high for exactly one cycle.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event and no change in `pressed_level`.
- **Reset mid-operation:** state returns to RELEASED and all counters/flags clear. If the button is still held after `reset_n` deasserts, a fresh full-latency `press_pulse` follows (no long-press carry-over).

## Timing
- **Reset:** while `reset_n`=0, all outputs are 0 and state is RELEASED. Outputs stay 0 on the first edge after deassertion.
- **Edge numbering:** edge 0 is the first rising edge that samples `button_raw` in the pressed level.
  - `sync_q` is 1 after edge 1.
  - PRESS_CHECK is entered at edge 2.
  - `press_pulse` is high in the cycle following edge `DEBOUNCE_CYCLES`+2.
- **Press latency:** `DEBOUNCE_CYCLES`+3 cycles from the raw edge to the pulse cycle.
- **Release latency:** identical, measured from the first edge sampling the released level.
- **Long press:** `long_press_pulse` is high in the cycle following edge `DEBOUNCE_CYCLES`+2+(`LONG_PRESS_CYCLES`-1), given a continuous hold.
- **Bounce reset:** any single-cycle reversion of `sync_q` in a CHECK state restarts the debounce from the stable state. Full `DEBOUNCE_CYCLES` are required again.
- **No throughput limit:** back-to-back press/release cycles are limited only by debounce time.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `ACTIVE_LOW`=0.
1. **Reset:** hold `reset_n`=0 for 3 cycles with `button_raw` toggling → all outputs 0. After release, outputs remain 0 while `button_raw`=0.
2. **Clean press and release:**
   - Raise `button_raw` at edge 0 and hold 10 cycles → `press_pulse` high only in the cycle after edge 6; `pressed_level`=1 from then.
   - Drop `button_raw` → `release_pulse` 7 cycles later; `pressed_level`=0 from then.
3. **Bounce rejection:**
   - Input pattern 1,1,0,1,1,1,1,1 from edge 0 → no pulse until 4 stable synchronised cycles after the last 0.
   - A 3-cycle high glitch alone → no events at all.
4. **Long press:**
   - Hold for 40 cycles → `press_pulse` after edge 6 and `long_press_pulse` after edge 25, each exactly once.
   - Release → `release_pulse`.
   - A second 40-cycle hold → long pulse again.
5. **Release bounce during hold:**
   - At hold_cnt ≈ 10, insert a 2-cycle low glitch → no `release_pulse`; `pressed_level` stays 1.
   - `long_press_pulse` still fires at edge 25.
6. **Mid-operation reset and polarity:**
   - Assert `reset_n`=0 for 2 cycles during a held press → outputs 0 immediately. A new `press_pulse` follows 7 cycles after deassertion.
   - Repeat scenario 2 with `ACTIVE_LOW`=1 and an inverted stimulus → identical response.

Source files
------------

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects one push-button: press/release/long-press pulses.
// Latency DEBOUNCE_CYCLES+3 from raw edge to pulse; no backpressure, pulses are fire-and-forget.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 260000,
  parameter int LONG_PRESS_CYCLES = 52000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic pressed_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                btn_norm, sync_meta, sync_q;
  logic [DB_W-1:0]     db_cnt, db_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                long_done;
  logic                holding, press_set, release_set, long_set;

  assign btn_norm = ACTIVE_LOW ? ~button_raw : button_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_norm;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  // Any reversion of sync_q inside a CHECK state falls straight back to the stable state.
  always_comb begin
    state_nxt = state;
    db_nxt    = db_cnt;
    case (state)
      RELEASED: begin
        if (sync_q) begin
          state_nxt = PRESS_CHECK;
          db_nxt    = '0;
        end
      end
      PRESS_CHECK: begin
        if (!sync_q)                state_nxt = RELEASED;
        else if (db_cnt == DB_LAST) state_nxt = PRESSED;
        else                        db_nxt    = db_cnt + 1'b1;
      end
      PRESSED: begin
        if (!sync_q) begin
          state_nxt = RELEASE_CHECK;
          db_nxt    = '0;
        end
      end
      RELEASE_CHECK: begin
        if (sync_q)                 state_nxt = PRESSED;
        else if (db_cnt == DB_LAST) state_nxt = RELEASED;
        else                        db_nxt    = db_cnt + 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // Long press fires on the edge the hold count reaches its last value, unless that edge releases.
  always_comb begin
    holding     = (state == PRESSED) || (state == RELEASE_CHECK);
    press_set   = (state == PRESS_CHECK) && (state_nxt == PRESSED);
    release_set = (state == RELEASE_CHECK) && (state_nxt == RELEASED);
    hold_nxt    = hold_cnt;
    if (state_nxt == RELEASED || press_set)
      hold_nxt = '0;
    else if (holding && hold_cnt != HOLD_LAST)
      hold_nxt = hold_cnt + 1'b1;
    long_set = holding && (state_nxt != RELEASED) && (hold_nxt == HOLD_LAST) && !long_done;
  end

  assign pressed_level = (state == PRESSED) || (state == RELEASE_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt           <= '0;
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      db_cnt           <= db_nxt;
      hold_cnt         <= hold_nxt;
      press_pulse      <= press_set;
      release_pulse    <= release_set;
      long_press_pulse <= long_set;
      if (state_nxt == RELEASED) long_done <= 1'b0;
      else if (long_set)         long_done <= 1'b1;
    end
  end

endmodule
